// File: rtl/des_pkg.sv
// Shared DES datapath widths and the block-loader pairing state encoding.
package des_pkg;
  localparam int DES_BLK_W  = 64;
  localparam int DES_HALF_W = 32;

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } ld_state_t;
endpackage

// File: rtl/des_block_fifo.sv
// DEPTH x 64-bit synchronous block FIFO with wrap-around pointers and a sync clear.
module des_block_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DES_BLK_W-1:0]    din,
  output logic [DES_BLK_W-1:0]    dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DEPTH-1:0][DES_BLK_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]                lvl_q, lvl_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    lvl_d  = lvl_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      lvl_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = din;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   lvl_d = lvl_q + LVL_W'(1);
        2'b01:   lvl_d = lvl_q - LVL_W'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  // Storage is reset so the head reads as zero until the first block lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lvl_q  <= lvl_d;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (lvl_q == LVL_W'(DEPTH));
  assign empty = (lvl_q == '0);
  assign level = lvl_q;
endmodule

// File: rtl/des_block_loader.sv
// Pairs 32-bit input words into 64-bit DES blocks and queues them for the IP stage.
module des_block_loader
  import des_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int WORD_SWAP = 0,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DES_HALF_W-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DES_BLK_W-1:0]    des_data,
  output logic                    half_pending,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        blk_count
);
  ld_state_t               state_q, state_d;
  logic [DES_HALF_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DES_BLK_W-1:0]    blk;
  logic                    fifo_full, fifo_empty;
  logic                    accept, push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HI;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sync_clr)    state_d = S_HI;
    else if (accept) state_d = (state_q == S_HI) ? S_LO : S_HI;
  end

  // in_ready looks only at registered state: a pop this cycle does not free a slot until next cycle.
  always_comb begin
    in_ready     = (state_q == S_HI) || !fifo_full;
    half_pending = (state_q == S_LO);
  end

  always_comb begin
    accept = in_valid && in_ready;
    push   = accept && (state_q == S_LO) && !sync_clr;
    pop    = out_valid && out_ready && !sync_clr;
    hold_d = hold_q;
    if (accept && (state_q == S_HI) && !sync_clr) hold_d = in_data;
    blk    = (WORD_SWAP != 0) ? {in_data, hold_q} : {hold_q, in_data};
    cnt_d  = cnt_q;
    if (sync_clr) cnt_d = '0;
    else if (pop) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  des_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sync_clr),
    .push  (push),
    .pop   (pop),
    .din   (blk),
    .dout  (des_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;
  assign blk_count = cnt_q;
endmodule

// File: tb/tb_des_block_loader.sv
// Drives a WORD_SWAP=0 and a WORD_SWAP=1 loader with shared stimulus against a queue-based model.
module tb_des_block_loader;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, sync_clr, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready0, out_valid0, half0, in_ready1, out_valid1, half1;
  logic [63:0] des0, des1;
  logic [1:0]  level0, level1;
  logic [15:0] cnt0, cnt1;

  int tests = 0;
  int errs  = 0;

  // model state: blocks stored as {first word, second word}
  logic [63:0] mq[$];
  logic        m_half;
  logic [31:0] m_first;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  des_block_loader #(.DEPTH(DEPTH), .WORD_SWAP(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .des_data(des0),
    .half_pending(half0), .level(level0), .blk_count(cnt0));

  des_block_loader #(.DEPTH(DEPTH), .WORD_SWAP(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .des_data(des1),
    .half_pending(half1), .level(level1), .blk_count(cnt1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_half  = 1'b0;
    m_first = '0;
    m_cnt   = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic rdy;
    rdy = !m_half || (mq.size() < DEPTH);
    if (sync_clr) begin
      mq.delete();
      m_half = 1'b0;
      m_cnt  = '0;
    end else begin
      if (mq.size() != 0 && out_ready) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (in_valid && rdy) begin
        if (!m_half) begin
          m_first = in_data;
          m_half  = 1'b1;
        end else begin
          mq.push_back({m_first, in_data});
          m_half = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic exp_rdy;
    logic [63:0] h;
    exp_rdy = !m_half || (mq.size() < DEPTH);
    chk("d0.in_ready",  64'(in_ready0),  64'(exp_rdy));
    chk("d1.in_ready",  64'(in_ready1),  64'(exp_rdy));
    chk("d0.out_valid", 64'(out_valid0), 64'(mq.size() != 0));
    chk("d1.out_valid", 64'(out_valid1), 64'(mq.size() != 0));
    chk("d0.half",      64'(half0),      64'(m_half));
    chk("d1.half",      64'(half1),      64'(m_half));
    chk("d0.level",     64'(level0),     64'(mq.size()));
    chk("d1.level",     64'(level1),     64'(mq.size()));
    chk("d0.blk_count", 64'(cnt0),       64'(m_cnt));
    chk("d1.blk_count", 64'(cnt1),       64'(m_cnt));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("d0.des_data", des0, h);
      chk("d1.des_data", des1, {h[31:0], h[63:32]});
    end
  endtask

  // Apply inputs after a falling edge, take the rising edge, compare at the next falling edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic clr);
    in_valid  = iv;
    in_data   = iv ? d : 32'hxxxx_xxxx;
    out_ready = ordy;
    sync_clr  = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid0 | out_valid1), 64'd0);
    chk({tag, ".half"},      64'(half0 | half1),           64'd0);
    chk({tag, ".in_ready"},  64'(in_ready0 & in_ready1),   64'd1);
    chk({tag, ".level"},     64'(level0 | level1),         64'd0);
    chk({tag, ".blk_count"}, 64'(cnt0 | cnt1),             64'd0);
    chk({tag, ".des0"},      des0,                         64'd0);
    chk({tag, ".des1"},      des1,                         64'd0);
  endtask

  initial begin
    rst_n = 1'b0; sync_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic pairing and one-cycle latency
    step(1'b1, 32'h0123_4567, 1'b1, 1'b0);
    chk("basic.valid_early", 64'(out_valid0), 64'd0);
    step(1'b1, 32'h89AB_CDEF, 1'b1, 1'b0);
    chk("basic.valid", 64'(out_valid0), 64'd1);
    chk("basic.des0", des0, 64'h0123_4567_89AB_CDEF);
    chk("basic.des1", des1, 64'h89AB_CDEF_0123_4567);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("basic.blk_count", 64'(cnt0), 64'd1);

    // backpressure: six words, sixth stalls in S_LO with the FIFO full
    for (int i = 0; i < 6; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    chk("bp.level", 64'(level0), 64'd2);
    chk("bp.half", 64'(half0), 64'd1);
    chk("bp.in_ready", 64'(in_ready0), 64'd0);
    step(1'b1, 32'hA000_0005, 1'b1, 1'b0);
    chk("bp.still_stalled", 64'(half0), 64'd1);
    step(1'b1, 32'hA000_0005, 1'b0, 1'b0);
    chk("bp.accepted", 64'(half0), 64'd0);
    chk("bp.head", des0, 64'hA000_0002_A000_0003);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // simultaneous push and pop at level 1
    step(1'b1, 32'hB000_0001, 1'b0, 1'b0);
    step(1'b1, 32'hB000_0002, 1'b0, 1'b0);
    step(1'b1, 32'hB000_0003, 1'b0, 1'b0);
    step(1'b1, 32'hB000_0004, 1'b1, 1'b0);
    chk("pp.level", 64'(level0), 64'd1);
    chk("pp.head", des0, 64'hB000_0003_B000_0004);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // sync_clr with a half block pending and a full FIFO
    for (int i = 0; i < 5; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hC000_00FF, 1'b1, 1'b1);
    chk("clr.valid", 64'(out_valid0), 64'd0);
    chk("clr.level", 64'(level0), 64'd0);
    chk("clr.blk_count", 64'(cnt0), 64'd0);
    chk("clr.half", 64'(half0), 64'd0);
    step(1'b1, 32'hD000_0001, 1'b0, 1'b0);
    step(1'b1, 32'hD000_0002, 1'b0, 1'b0);
    chk("clr.fresh", des0, 64'hD000_0001_D000_0002);

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) != 0, $urandom_range(0, 39) == 0);

    // asynchronous reset mid-block, between edges
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hE000_0001, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0; sync_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("areset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hF000_0001, 1'b0, 1'b0);
    step(1'b1, 32'hF000_0002, 1'b0, 1'b0);
    chk("areset.fresh", des0, 64'hF000_0001_F000_0002);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/des_block_loader.md
Name: des_block_loader

Overview:
- Upstream stage of the DES datapath. Accepts 32-bit words over a valid/ready stream and pairs them into 64-bit blocks.
- Buffers completed blocks in a small FIFO.
- Presents each block as des_data, with its own valid/ready handshake, to the initial-permutation stage and round engine.
- Decouples the host bus from the core so that the core sees only whole, back-to-back blocks.

Parameters:
- DEPTH, 2: number of 64-bit block entries in the FIFO; power of two, minimum 2.
- WORD_SWAP, 0: 0 = first word accepted forms des_data[63:32]; 1 = first word forms des_data[31:0].
- CNT_W, 16: width of the block counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous flush of the half-block and the FIFO; also zeroes blk_count.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  32  input word.
- out_valid  out  1  des_data holds a complete block.
- out_ready  in  1  consumer takes the block when out_valid && out_ready.
- des_data  out  64  head block, in the bit order expected by the IP stage (bit 63 = first transmitted bit).
- half_pending  out  1  first word of a block is held and its pair is awaited.
- level  out  $clog2(DEPTH)+1  number of full blocks in the FIFO.
- blk_count  out  CNT_W  blocks delivered on the output handshake.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = S_HI; FIFO empty; level = 0; blk_count = 0.
  - out_valid = 0; half_pending = 0; des_data = 0; in_ready = 1.
- Pairing FSM has two states: S_HI (waiting for the first word) and S_LO (first word held in hold_reg).
  - S_HI: in_ready = 1. On accept, hold_reg <= in_data and go to S_LO.
  - S_LO: in_ready = (level != DEPTH). On accept, push the block and go to S_HI.
- Block push contents:
  - WORD_SWAP = 0: {hold_reg, in_data}.
  - WORD_SWAP = 1: {in_data, hold_reg}.
- in_ready depends only on registered state. It has no combinational path from out_ready.
  - When the FIFO is full, the second word stalls even if a pop happens in the same cycle.
  - In that case it is accepted on the following cycle.
- half_pending = (state == S_LO).
- FIFO:
  - Registered storage with a wrap-around read pointer and write pointer, each $clog2(DEPTH) bits.
  - out_valid = (level != 0).
  - des_data = entry at the read pointer. It is stable while out_valid && !out_ready.
- Latency: second word accepted at edge N while the FIFO is empty gives out_valid = 1 after edge N, i.e. visible in cycle N+1. Throughput is one block per two input words.
- Simultaneous push and pop: level is unchanged and both pointers advance.
  - Pop from an empty FIFO: impossible, since out_valid = 0.
  - Push into a full FIFO: impossible, since in_ready = 0.
- blk_count increments on each out_valid && out_ready and wraps from all-ones to 0.
- sync_clr has priority over every handshake in the same cycle:
  - state <= S_HI; pointers and level <= 0; blk_count <= 0; hold_reg is not cleared.
  - Data offered or consumed in that cycle is discarded. The producer must treat any in_valid && in_ready in that cycle as dropped.
- Reset mid-block: the partial word is lost and the next accepted word is the first word of a block.
- X on in_data while in_valid = 0 must never reach des_data.

Decomposition:
- des_pkg holds DES_BLK_W = 64, DES_HALF_W = 32 and the typedef ld_state_t {S_HI, S_LO}. The IP and round stages use the same width constants.
- One sub-module, des_block_fifo: a generic DEPTH×64 synchronous FIFO with push, pop, full, empty, level and sync clear.
- des_block_loader instantiates des_block_fifo and contains the pairing FSM, the swap mux and the counter.

Test Plan:
- Basic pairing: after reset, send 0x01234567 then 0x89ABCDEF with out_ready = 1 and WORD_SWAP = 0.
  - Expect des_data = 0x0123456789ABCDEF and out_valid high in the cycle after the second accept.
  - Expect blk_count = 1.
- WORD_SWAP = 1: send the same two words. Expect des_data = 0x89ABCDEF01234567.
- Backpressure: hold out_ready = 0 and stream 6 words with DEPTH = 2.
  - Expect level = 2, half_pending = 1, and in_ready = 0 in S_LO.
  - Then raise out_ready for one cycle. Expect the stalled word accepted the next cycle, blocks emerge in order, and des_data is stable while stalled.
- Simultaneous push and pop at level = 1: level stays 1 and the output order is preserved.
- sync_clr while half_pending = 1 and level = 2:
  - Expect out_valid = 0, level = 0, blk_count = 0 and half_pending = 0 on the next cycle.
  - The next two words form a fresh block.
- Async reset asserted mid-stream, between clock edges: all outputs take their reset values immediately, and the first post-reset word starts a new block.
